multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control unit for the multicycle RV32I core. It replaces the single-cycle combinational main decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback across several cycles over a shared memory port, and it folds in the ALU decoder. It supports lw, sw, R-type ALU, I-type ALU, beq/bne and jal, with an optional wait-state handshake to memory. It drives the datapath select and enable lines directly.

## Interface
- MEM_WAIT, default 0, meaning:
  - 1: memory states stall until `mem_ready`.
  - 0: `mem_ready` is ignored and treated as 1.
- BNE_EN, default 1, meaning:
  - 1: funct3=001 branches are taken on `!zero`.
  - 0: funct3=001 branches are never taken.

Ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- op  in  7  instruction[6:0] from the instruction register.
- funct3  in  3  instruction[14:12].
- funct7b5  in  1  instruction[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  IR/OldPC enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = 4.
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- RegWrite  out  1  register file write enable.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state  out  4  current state encoding, for debug.

## Operation
- State encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5.
  - EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, JAL 10.
  - Codes 11–15 are unused and go to FETCH on the next edge.
- Outputs per state. Any output not listed is 0; ALUOp is internal.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch/jump target).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE, by op:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1100011 → BRANCH.
    - 1101111 → JAL.
    - any other op → FETCH, with illegal_op=1 during the DECODE cycle.
  - MEMADR→MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER and EXECUTEI→ALUWB→FETCH.
  - JAL→ALUWB.
  - BRANCH→FETCH.
- Wait states, MEM_WAIT=1 only:
  - FETCH, MEMREAD and MEMWRITE hold while mem_ready=0.
  - In FETCH, IRWrite and PCUpdate are gated by mem_ready.
  - MemWrite stays high throughout a stalled MEMWRITE.
  - All other outputs hold their state values while stalled.
- PCWrite = PCUpdate | (Branch & take).
  - take = zero when funct3=000.
  - take = !zero when funct3=001 and BNE_EN=1.
  - take = 0 otherwise.
- ALU decoder:
  - ALUOp 00 → 000 (add).
  - ALUOp 01 → 001 (sub).
  - ALUOp 10, by funct3:
    - 000 → 001 if (op[5] & funct7b5), else 000.
    - 010 → 101.
    - 110 → 011.
    - 111 → 010.
    - any other funct3 → 000.
- ImmSrc is combinational from op in every state:
  - 0100011 → 01.
  - 1100011 → 10.
  - 1101111 → 11.
  - any other op → 00.

## Timing
- The state register updates on the rising edge of clk. All outputs are combinational from state, op, funct3, funct7b5, zero and mem_ready.
- Reset:
  - Asserting reset forces state=FETCH immediately, asynchronously.
  - While reset is high, PCWrite, IRWrite, MemWrite, RegWrite and illegal_op are forced to 0. Every other output shows its FETCH value.
  - The first fetch completes on the first rising edge after reset deasserts (with mem_ready=1).
- Latency with zero wait states, counting from FETCH through the last state:
  - lw: 5 cycles.
  - sw, R-type, I-type and jal: 4 cycles.
  - beq/bne: 3 cycles.
- Each stalled cycle adds 1 cycle to the instruction.
- Reset asserted in any state, including mid-stall with MemWrite high, aborts the instruction. MemWrite drops in the same cycle.

## Test plan
- **R-type add then sub:** add (op=0110011, funct3=000, funct7b5=0), then sub (funct7b5=1), mem_ready=1.
  - State sequence 0,1,6,8,0 for each.
  - ALUControl=000 for add and 001 for sub in EXECUTER.
  - RegWrite=1 only in state 8.
- **lw / sw:** lw (op=0000011) gives states 0,1,2,3,4; AdrSrc=1 in state 3; ResultSrc=01 and RegWrite=1 in state 4. sw (op=0100011) gives states 0,1,2,5; MemWrite=1 only in state 5; ImmSrc=01.
- **Branches** (op=1100011):
  - funct3=000 with zero=1: PCWrite=1 in BRANCH.
  - funct3=000 with zero=0: PCWrite=0.
  - funct3=001 with zero=0: PCWrite=1 when BNE_EN=1, 0 when BNE_EN=0.
- **Wait states** (MEM_WAIT=1): hold mem_ready=0 for 2 cycles in FETCH, then 1.
  - state stays 0 for 3 cycles.
  - IRWrite and PCWrite are 1 only in the third cycle.
  - sw with 1 stall shows MemWrite=1 for 2 cycles.
- **Illegal opcode and jal:**
  - op=1111111 gives illegal_op=1 for one cycle in DECODE, then state 0.
  - jal (op=1101111) gives states 0,1,10,8; ImmSrc=11; PCWrite=1 in state 10.
- **Reset mid-instruction:** assert reset asynchronously during MEMWRITE.
  - state=0 and MemWrite=0 without waiting for a clock edge.
  - All write enables stay 0 until reset deasserts.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore sequencer for fetch/decode/execute/memory/writeback
// with an optional memory wait-state handshake and the ALU decoder folded in.
`timescale 1ns/1ps

module multicycle_controller #(
  parameter bit MEM_WAIT = 1'b0,
  parameter bit BNE_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic       rdy, pc_update, branch, take;
  logic       irwrite_s, memwrite_s, regwrite_s, illegal_s;
  logic [1:0] alu_op;

  assign rdy = MEM_WAIT ? mem_ready : 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    alu_op     = 2'b00;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    illegal_s  = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irwrite_s = rdy;
        pc_update = rdy;
        state_d   = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b0110011:             state_d = EXECUTER;
          7'b0010011:             state_d = EXECUTEI;
          7'b1100011:             state_d = BRANCH;
          7'b1101111:             state_d = JAL;
          default:                illegal_s = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = rdy ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        regwrite_s = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        memwrite_s = 1'b1;
        state_d    = rdy ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: regwrite_s = 1'b1;
      BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  take = zero;
      3'b001:  take = BNE_EN & ~zero;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

  // Write enables are masked by reset directly so an aborted store drops MemWrite at once.
  assign PCWrite    = ~reset & (pc_update | (branch & take));
  assign IRWrite    = ~reset & irwrite_s;
  assign MemWrite   = ~reset & memwrite_s;
  assign RegWrite   = ~reset & regwrite_s;
  assign illegal_op = ~reset & illegal_s;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller: two instances
// (no wait states / BNE on, and wait states / BNE off) checked against a phase-table model.
`timescale 1ns/1ps

module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_s   [2];
  logic [6:0] op_s      [2];
  logic [2:0] funct3_s  [2];
  logic       funct7b5_s[2];
  logic       zero_s    [2];
  logic       ready_s   [2];
  logic       pcwrite_o [2];
  logic       adrsrc_o  [2];
  logic       memwrite_o[2];
  logic       irwrite_o [2];
  logic [1:0] resultsrc_o[2];
  logic [1:0] srca_o    [2];
  logic [1:0] srcb_o    [2];
  logic [2:0] aluctl_o  [2];
  logic [1:0] immsrc_o  [2];
  logic       regwrite_o[2];
  logic       illegal_o [2];
  logic [3:0] state_o   [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    multicycle_controller #(.MEM_WAIT(g == 1), .BNE_EN(g == 0)) dut (
      .clk        (clk),
      .reset      (reset_s[g]),
      .op         (op_s[g]),
      .funct3     (funct3_s[g]),
      .funct7b5   (funct7b5_s[g]),
      .zero       (zero_s[g]),
      .mem_ready  (ready_s[g]),
      .PCWrite    (pcwrite_o[g]),
      .AdrSrc     (adrsrc_o[g]),
      .MemWrite   (memwrite_o[g]),
      .IRWrite    (irwrite_o[g]),
      .ResultSrc  (resultsrc_o[g]),
      .ALUSrcA    (srca_o[g]),
      .ALUSrcB    (srcb_o[g]),
      .ALUControl (aluctl_o[g]),
      .ImmSrc     (immsrc_o[g]),
      .RegWrite   (regwrite_o[g]),
      .illegal_op (illegal_o[g]),
      .state      (state_o[g])
    );
  end

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    return o inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL};
  endfunction

  // Expected outputs packed as {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
  // ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite, illegal_op}.
  function automatic logic [16:0] exp_outs(input int s, input bit rdy, input bit mw, input bit be,
                                           input logic [6:0] o, input logic [2:0] f3,
                                           input bit f7, input bit z, input bit rst);
    bit pcw = 0, adr = 0, memw = 0, irw = 0, rw = 0, ill = 0, take;
    logic [1:0] rs = 0, sa = 0, sb = 0, imm;
    logic [2:0] alu = 3'd0;
    bit ready = mw ? rdy : 1'b1;
    take = (f3 == 3'd0) ? z : ((f3 == 3'd1 && be) ? !z : 1'b0);
    case (s)
      0:  begin irw = ready; pcw = ready; sb = 2'b10; rs = 2'b10; end
      1:  begin sa = 2'b01; sb = 2'b01; ill = !is_legal(o); end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  adr = 1;
      4:  begin rs = 2'b01; rw = 1; end
      5:  begin adr = 1; memw = 1; end
      6:  sa = 2'b10;
      7:  begin sa = 2'b10; sb = 2'b01; end
      8:  rw = 1;
      9:  begin sa = 2'b10; alu = 3'b001; pcw = take; end
      10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      default: ;
    endcase
    if (s == 6 || s == 7) begin
      case (f3)
        3'b000:  alu = (o[5] && f7) ? 3'b001 : 3'b000;
        3'b010:  alu = 3'b101;
        3'b110:  alu = 3'b011;
        3'b111:  alu = 3'b010;
        default: alu = 3'b000;
      endcase
    end
    imm = (o == OP_SW) ? 2'b01 : (o == OP_BR) ? 2'b10 : (o == OP_JAL) ? 2'b11 : 2'b00;
    if (rst) begin pcw = 0; irw = 0; memw = 0; rw = 0; ill = 0; end
    return {pcw, adr, memw, irw, rs, sa, sb, alu, imm, rw, ill};
  endfunction

  function automatic logic [16:0] got_outs(input int d);
    return {pcwrite_o[d], adrsrc_o[d], memwrite_o[d], irwrite_o[d], resultsrc_o[d],
            srca_o[d], srcb_o[d], aluctl_o[d], immsrc_o[d], regwrite_o[d], illegal_o[d]};
  endfunction

  task automatic compare(input int d, input int s, input bit rst);
    string tag;
    tag = $sformatf("d%0d op=%b f3=%0d st%0d rst%0d", d, op_s[d], funct3_s[d], s, rst);
    check({tag, " state"}, 32'(state_o[d]), 32'(s));
    check({tag, " outs"}, 32'(got_outs(d)),
          32'(exp_outs(s, ready_s[d], d == 1, d == 0, op_s[d], funct3_s[d],
                       funct7b5_s[d], zero_s[d], rst)));
  endtask

  // One clock cycle: drive mem_ready, check mid-cycle, then advance past the edge.
  task automatic step(input int d, input int s, input bit rdy);
    ready_s[d] = rdy;
    @(negedge clk);
    compare(d, s, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH on instance d; nst = stalled cycles per memory state.
  task automatic run_instr(input int d, input logic [6:0] o, input logic [2:0] f3,
                           input bit f7, input bit z, input int nst);
    int seq[$];
    reset_s[1-d] = 1'b1;
    reset_s[d]   = 1'b0;
    op_s[d] = o; funct3_s[d] = f3; funct7b5_s[d] = f7; zero_s[d] = z;
    seq.push_back(0);
    seq.push_back(1);
    case (o)
      OP_LW:   begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
      OP_SW:   begin seq.push_back(2); seq.push_back(5); end
      OP_R:    begin seq.push_back(6); seq.push_back(8); end
      OP_I:    begin seq.push_back(7); seq.push_back(8); end
      OP_BR:   seq.push_back(9);
      OP_JAL:  begin seq.push_back(10); seq.push_back(8); end
      default: ;
    endcase
    foreach (seq[k]) begin
      bit mem_phase = (d == 1) && (seq[k] inside {0, 3, 5});
      int n = mem_phase ? nst : 0;
      for (int c = 0; c <= n; c++)
        step(d, seq[k], mem_phase ? (c == n) : 1'($urandom % 2));
    end
  endtask

  // Stalled store on the wait-state instance, aborted by an asynchronous reset.
  task automatic reset_mid_store();
    reset_s[0] = 1'b1;
    reset_s[1] = 1'b0;
    op_s[1] = OP_SW; funct3_s[1] = 3'b010; funct7b5_s[1] = 1'b0; zero_s[1] = 1'b0;
    step(1, 0, 1'b1);
    step(1, 1, 1'b1);
    step(1, 2, 1'b1);
    ready_s[1] = 1'b0;
    @(negedge clk);
    compare(1, 5, 1'b0);
    #2;
    reset_s[1] = 1'b1;
    #1;
    compare(1, 0, 1'b1);
    @(posedge clk);
    #1;
    compare(1, 0, 1'b1);
    @(negedge clk);
    compare(1, 0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset_s[d] = 1'b1; op_s[d] = OP_R; funct3_s[d] = 3'd0; funct7b5_s[d] = 1'b0;
      zero_s[d] = 1'b0; ready_s[d] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) compare(d, 0, 1'b1);

    // Directed cases from the feature list.
    run_instr(0, OP_R, 3'b000, 1'b0, 1'b0, 0);
    run_instr(0, OP_R, 3'b000, 1'b1, 1'b0, 0);
    run_instr(0, OP_LW, 3'b010, 1'b0, 1'b0, 0);
    run_instr(0, OP_SW, 3'b010, 1'b0, 1'b0, 0);
    run_instr(0, OP_BR, 3'b000, 1'b0, 1'b1, 0);
    run_instr(0, OP_BR, 3'b000, 1'b0, 1'b0, 0);
    run_instr(0, OP_BR, 3'b001, 1'b0, 1'b0, 0);
    run_instr(1, OP_BR, 3'b001, 1'b0, 1'b0, 0);
    run_instr(1, OP_I, 3'b111, 1'b0, 1'b0, 2);
    run_instr(1, OP_SW, 3'b010, 1'b0, 1'b0, 1);
    run_instr(1, OP_LW, 3'b010, 1'b0, 1'b0, 2);
    run_instr(0, 7'b1111111, 3'b000, 1'b0, 1'b0, 0);
    run_instr(0, OP_JAL, 3'b000, 1'b0, 1'b0, 0);
    run_instr(0, OP_I, 3'b000, 1'b1, 1'b0, 0);
    reset_mid_store();
    run_instr(1, OP_R, 3'b110, 1'b0, 1'b0, 0);

    for (int i = 0; i < 200; i++) begin
      int d = int'($urandom % 2);
      int cls = int'($urandom % 7);
      logic [6:0] o;
      logic [2:0] f3 = 3'($urandom);
      case (cls)
        0: o = OP_LW;
        1: o = OP_SW;
        2: o = OP_R;
        3: o = OP_I;
        4: begin
          o = OP_BR;
          if ($urandom % 4 != 0) f3 = 3'($urandom % 2);
        end
        5: o = OP_JAL;
        default: begin
          o = 7'($urandom);
          while (is_legal(o)) o = 7'($urandom);
        end
      endcase
      run_instr(d, o, f3, 1'($urandom), 1'($urandom), int'($urandom % 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
